// File: rtl/demux8_buf.sv
// -----------------------------------------------------------------------------
// demux8_buf
//   1-to-8 registered demultiplexer with per-lane valid/ready handshakes.
//   A WIDTH-bit word tagged with a 3-bit destination index is written into one
//   of eight one-entry output buffers and becomes visible one clock later.
//   Each lane drains independently, so a stalled consumer only blocks words
//   addressed to its own lane.
//
// Optional feature (compile-time macro DEMUX_BCAST_EN):
//   Adds the in_bcast input. A broadcast word is written to all eight lanes at
//   once, and only when every lane can take it (all-or-nothing).
//   Without the macro the in_bcast port does not exist.
//
// Ports
//   clk        in   1        clock, rising edge
//   reset_n    in   1        asynchronous active-low reset
//   in_valid   in   1        in_data / in_sel valid this cycle
//   in_ready   out  1        presented word can be accepted this cycle
//   in_data    in   WIDTH    word to route
//   in_sel     in   3        destination lane 0..7
//   in_bcast   in   1        broadcast request (DEMUX_BCAST_EN only)
//   out_valid  out  8        lane i holds a valid word
//   out_ready  in   8        consumer i takes lane i's word this cycle
//   out_data   out  8*WIDTH  lane i word at [i*WIDTH +: WIDTH]
// -----------------------------------------------------------------------------
module demux8_buf #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_sel,
`ifdef DEMUX_BCAST_EN
  input  logic               in_bcast,
`endif
  output logic [7:0]         out_valid,
  input  logic [7:0]         out_ready,
  output logic [8*WIDTH-1:0] out_data
);

  logic [7:0]       out_valid_r;
  logic [WIDTH-1:0] lane_data_r [8];

  logic [7:0] free_s;
  logic [7:0] wr_en_s;
  logic       ready_s;
  logic       accept_s;

  // Lane availability, input handshake and per-lane write enables.
  // A lane is free when empty or when its consumer drains it this cycle,
  // which gives one word per clock per lane. in_ready never looks at in_valid.
  always_comb begin
    free_s  = ~out_valid_r | out_ready;
    wr_en_s = 8'h00;
`ifdef DEMUX_BCAST_EN
    if (in_bcast) begin
      ready_s = &free_s;
    end else begin
      ready_s = free_s[in_sel];
    end
`else
    ready_s = free_s[in_sel];
`endif
    accept_s = in_valid & ready_s;
    if (accept_s) begin
`ifdef DEMUX_BCAST_EN
      if (in_bcast) begin
        wr_en_s = 8'hFF;
      end else begin
        wr_en_s = 8'h01 << in_sel;
      end
`else
      wr_en_s = 8'h01 << in_sel;
`endif
    end else begin
      wr_en_s = 8'h00;
    end
  end

  // Per-lane buffer state: a write wins over a drain, so a same-cycle
  // drain+refill keeps the lane FULL with the new word. Data is held while
  // the lane is empty or stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        lane_data_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_en_s[i]) begin
          out_valid_r[i] <= 1'b1;
          lane_data_r[i] <= in_data;
        end else if (out_ready[i]) begin
          out_valid_r[i] <= 1'b0;
          lane_data_r[i] <= lane_data_r[i];
        end else begin
          out_valid_r[i] <= out_valid_r[i];
          lane_data_r[i] <= lane_data_r[i];
        end
      end
    end
  end

  assign in_ready  = ready_s;
  assign out_valid = out_valid_r;

  // Flatten the lane registers onto the packed output bus.
  for (genvar g = 0; g < 8; g++) begin : g_lane_out
    assign out_data[g*WIDTH +: WIDTH] = lane_data_r[g];
  end

endmodule
